// File: rtl/admm_pkg.sv
// Shared ADMM solver definitions: fixed-point word, sweep phase and state
// encodings, RAM read latency and horizon clamping.
package admm_pkg;

    localparam int FXP_WIDTH  = 16;
    localparam int FXP_FRAC   = 8;
    localparam int RD_LATENCY = 2;

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        ADDR = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IN_SWEEP   = 2'd1,
        ST_SWEEP   = 2'd2,
        DONE_STATE = 2'd3
    } sweep_t;

    // At least two stages are needed so the input sweep (k = 0..Nh-2) is non-empty.
    function automatic logic [31:0] clamp_horizon(input logic [31:0] req, input int hmax);
        if (req < 32'd2)
            return 32'd2;
        if (req > 32'(hmax))
            return 32'(hmax);
        return req;
    endfunction

endpackage

// File: rtl/fxp_sat_addsub.sv
// Saturating two's-complement add/subtract with a saturated magnitude output.
// The sum is formed one bit wider than the operands, then clamped; the
// magnitude of the most negative value clamps to the most positive value.
module fxp_sat_addsub #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] result,
    output logic signed [W-1:0] magnitude
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] wide;

    // Wide add/sub, clamp on overflow, then take the clamped absolute value.
    always_comb begin
        wide = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        if (wide[W] != wide[W-1])
            result = wide[W] ? MIN_V : MAX_V;
        else
            result = wide[W-1:0];
        if (result == MIN_V)
            magnitude = MAX_V;
        else if (result[W-1])
            magnitude = -result;
        else
            magnitude = result;
    end

endmodule

// File: rtl/dual_update.sv
// ADMM dual-variable update and residual stage.
// Sweeps the input trajectory (y += u - z) then the state trajectory
// (g += x - v) in place, one element every four cycles (ADDR, WAIT, CAP, WR).
// Build option DUAL_UPDATE_RESIDUAL_EN: when defined, max-abs residuals and
// the converged flag are built; otherwise they (and z_prev_rdaddress) read 0.
//
// state      | meaning
// IDLE       | waiting for start, residual outputs hold last sweep
// IN_SWEEP   | y update over k = 0..Nh-2, i = 0..INPUT_DIM-1
// ST_SWEEP   | g update over k = 0..Nh-1, i = 0..STATE_DIM-1
// DONE_STATE | done high until start drops
module dual_update
    import admm_pkg::*;
#(
    parameter int STATE_DIM  = 12,
    parameter int INPUT_DIM  = 4,
    parameter int HORIZON    = 30,
    parameter int DATA_WIDTH = FXP_WIDTH,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  active_horizon,
    output logic [ADDR_WIDTH-1:0]        u_rdaddress,
    output logic [ADDR_WIDTH-1:0]        z_rdaddress,
    output logic [ADDR_WIDTH-1:0]        z_prev_rdaddress,
    output logic [ADDR_WIDTH-1:0]        y_rdaddress,
    input  logic signed [DATA_WIDTH-1:0] u_data_out,
    input  logic signed [DATA_WIDTH-1:0] z_data_out,
    input  logic signed [DATA_WIDTH-1:0] z_prev_data_out,
    input  logic signed [DATA_WIDTH-1:0] y_data_out,
    output logic [ADDR_WIDTH-1:0]        y_wraddress,
    output logic signed [DATA_WIDTH-1:0] y_data_in,
    output logic                         y_wren,
    output logic [ADDR_WIDTH-1:0]        x_rdaddress,
    output logic [ADDR_WIDTH-1:0]        v_rdaddress,
    output logic [ADDR_WIDTH-1:0]        g_rdaddress,
    input  logic signed [DATA_WIDTH-1:0] x_data_out,
    input  logic signed [DATA_WIDTH-1:0] v_data_out,
    input  logic signed [DATA_WIDTH-1:0] g_data_out,
    output logic [ADDR_WIDTH-1:0]        g_wraddress,
    output logic signed [DATA_WIDTH-1:0] g_data_in,
    output logic                         g_wren,
    input  logic signed [DATA_WIDTH-1:0] eps_pri,
    input  logic signed [DATA_WIDTH-1:0] eps_dual,
    output logic signed [DATA_WIDTH-1:0] pri_res_u,
    output logic signed [DATA_WIDTH-1:0] pri_res_x,
    output logic signed [DATA_WIDTH-1:0] dual_res,
    output logic                         converged,
    output logic                         done
);

    sweep_t                       state;
    phase_t                       phase;
    logic [ADDR_WIDTH-1:0]        idx;
    logic [ADDR_WIDTH-1:0]        u_last;
    logic [ADDR_WIDTH-1:0]        x_last;
    logic [31:0]                  nh;
    logic signed [DATA_WIDTH-1:0] cap_a;
    logic signed [DATA_WIDTH-1:0] cap_b;
    logic signed [DATA_WIDTH-1:0] cap_c;
    logic signed [DATA_WIDTH-1:0] diff;
    logic signed [DATA_WIDTH-1:0] diff_mag;
    logic signed [DATA_WIDTH-1:0] upd;
    logic signed [DATA_WIDTH-1:0] upd_mag_unused;
    logic                         in_wr;
    logic                         st_wr;
    logic                         last_elem;

    assign nh        = clamp_horizon(active_horizon, HORIZON);
    assign in_wr     = (state == IN_SWEEP) && (phase == WR);
    assign st_wr     = (state == ST_SWEEP) && (phase == WR);
    assign last_elem = (state == IN_SWEEP) ? (idx == u_last) : (idx == x_last);

    // One datapath serves both sweeps: cap_a/cap_b/cap_c hold u/z/y or x/v/g.
    fxp_sat_addsub #(.W(DATA_WIDTH)) u_diff (
        .a(cap_a), .b(cap_b), .sub(1'b1), .result(diff), .magnitude(diff_mag)
    );
    fxp_sat_addsub #(.W(DATA_WIDTH)) u_upd (
        .a(cap_c), .b(diff), .sub(1'b0), .result(upd), .magnitude(upd_mag_unused)
    );

    // Sweep sequencer: four-phase element walk, one contiguous index per sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= ADDR;
            idx    <= '0;
            u_last <= '0;
            x_last <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_c  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        u_last <= ADDR_WIDTH'(32'(INPUT_DIM) * (nh - 32'd1) - 32'd1);
                        x_last <= ADDR_WIDTH'(32'(STATE_DIM) * nh - 32'd1);
                        idx    <= '0;
                        phase  <= ADDR;
                        state  <= IN_SWEEP;
                    end
                end
                IN_SWEEP, ST_SWEEP: begin
                    case (phase)
                        ADDR: phase <= WAIT;
                        WAIT: phase <= CAP;
                        CAP: begin
                            if (state == IN_SWEEP) begin
                                cap_a <= u_data_out;
                                cap_b <= z_data_out;
                                cap_c <= y_data_out;
                            end else begin
                                cap_a <= x_data_out;
                                cap_b <= v_data_out;
                                cap_c <= g_data_out;
                            end
                            phase <= WR;
                        end
                        WR: begin
                            phase <= ADDR;
                            if (last_elem) begin
                                idx   <= '0;
                                state <= (state == IN_SWEEP) ? ST_SWEEP : DONE_STATE;
                            end else begin
                                idx <= idx + ADDR_WIDTH'(1);
                            end
                        end
                        default: phase <= ADDR;
                    endcase
                end
                DONE_STATE: begin
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign u_rdaddress = (state == IN_SWEEP) ? idx : '0;
    assign z_rdaddress = (state == IN_SWEEP) ? idx : '0;
    assign y_rdaddress = (state == IN_SWEEP) ? idx : '0;
    assign x_rdaddress = (state == ST_SWEEP) ? idx : '0;
    assign v_rdaddress = (state == ST_SWEEP) ? idx : '0;
    assign g_rdaddress = (state == ST_SWEEP) ? idx : '0;

    assign y_wren      = in_wr;
    assign y_wraddress = in_wr ? idx : '0;
    assign y_data_in   = in_wr ? upd : '0;
    assign g_wren      = st_wr;
    assign g_wraddress = st_wr ? idx : '0;
    assign g_data_in   = st_wr ? upd : '0;
    assign done        = (state == DONE_STATE);

`ifdef DUAL_UPDATE_RESIDUAL_EN
    logic signed [DATA_WIDTH-1:0] cap_d;
    logic signed [DATA_WIDTH-1:0] dual_diff_unused;
    logic signed [DATA_WIDTH-1:0] dual_mag;
    logic signed [DATA_WIDTH-1:0] res_u;
    logic signed [DATA_WIDTH-1:0] res_x;
    logic signed [DATA_WIDTH-1:0] res_d;
    logic signed [DATA_WIDTH-1:0] res_pri;

    // cap_b holds z during the input sweep, so |z - z_prev| reuses it.
    fxp_sat_addsub #(.W(DATA_WIDTH)) u_dual (
        .a(cap_b), .b(cap_d), .sub(1'b1), .result(dual_diff_unused), .magnitude(dual_mag)
    );

    // Running max-abs residuals, cleared on start and held after the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_d <= '0;
            res_u <= '0;
            res_x <= '0;
            res_d <= '0;
        end else if (state == IDLE && start) begin
            res_u <= '0;
            res_x <= '0;
            res_d <= '0;
        end else begin
            if (state == IN_SWEEP && phase == CAP)
                cap_d <= z_prev_data_out;
            if (in_wr) begin
                if (diff_mag > res_u)
                    res_u <= diff_mag;
                if (dual_mag > res_d)
                    res_d <= dual_mag;
            end
            if (st_wr && diff_mag > res_x)
                res_x <= diff_mag;
        end
    end

    assign res_pri          = (res_u > res_x) ? res_u : res_x;
    assign converged        = done && (res_pri <= eps_pri) && (res_d <= eps_dual);
    assign pri_res_u        = res_u;
    assign pri_res_x        = res_x;
    assign dual_res         = res_d;
    assign z_prev_rdaddress = (state == IN_SWEEP) ? idx : '0;
`else
    logic unused_inputs;

    assign unused_inputs    = ^{z_prev_data_out, eps_pri, eps_dual};
    assign converged        = 1'b0;
    assign pri_res_u        = '0;
    assign pri_res_x        = '0;
    assign dual_res         = '0;
    assign z_prev_rdaddress = '0;
`endif

endmodule

// File: tb/tb_dual_update.sv
// Bench for dual_update: RAM models with two-cycle read latency, an
// arithmetic reference of the sweep, and directed plus random sweeps.
// Residual expectations follow the DUAL_UPDATE_RESIDUAL_EN build option.
module tb_dual_update;

    localparam int SD = 12;
    localparam int ID = 4;
    localparam int HZ = 30;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [31:0]        active_horizon;
    logic signed [15:0] eps_pri;
    logic signed [15:0] eps_dual;
    logic [8:0]         u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress;
    logic [8:0]         x_rdaddress, v_rdaddress, g_rdaddress;
    logic [8:0]         y_wraddress, g_wraddress;
    logic signed [15:0] y_data_in, g_data_in;
    logic               y_wren, g_wren;
    logic signed [15:0] pri_res_u, pri_res_x, dual_res;
    logic               converged, done;

    logic signed [15:0] u_mem [0:511];
    logic signed [15:0] z_mem [0:511];
    logic signed [15:0] zp_mem[0:511];
    logic signed [15:0] y_mem [0:511];
    logic signed [15:0] x_mem [0:511];
    logic signed [15:0] v_mem [0:511];
    logic signed [15:0] g_mem [0:511];
    logic signed [15:0] u_p1, u_p2, z_p1, z_p2, zp_p1, zp_p2, y_p1, y_p2;
    logic signed [15:0] x_p1, x_p2, v_p1, v_p2, g_p1, g_p2;

    int exp_y[0:511];
    int exp_g[0:511];
    int exp_ru, exp_rx, exp_rd;
    int exp_conv;
    int n_cmp = 0;
    int n_bad = 0;

    logic any_out;
    assign any_out = |{u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress,
                       x_rdaddress, v_rdaddress, g_rdaddress, y_wraddress, g_wraddress,
                       y_data_in, g_data_in, y_wren, g_wren, pri_res_u, pri_res_x,
                       dual_res, converged, done};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        u_p1 <= u_mem[u_rdaddress];   u_p2 <= u_p1;
        z_p1 <= z_mem[z_rdaddress];   z_p2 <= z_p1;
        zp_p1 <= zp_mem[z_prev_rdaddress]; zp_p2 <= zp_p1;
        y_p1 <= y_mem[y_rdaddress];   y_p2 <= y_p1;
        x_p1 <= x_mem[x_rdaddress];   x_p2 <= x_p1;
        v_p1 <= v_mem[v_rdaddress];   v_p2 <= v_p1;
        g_p1 <= g_mem[g_rdaddress];   g_p2 <= g_p1;
    end

    dual_update dut (
        .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
        .u_rdaddress(u_rdaddress), .z_rdaddress(z_rdaddress),
        .z_prev_rdaddress(z_prev_rdaddress), .y_rdaddress(y_rdaddress),
        .u_data_out(u_p2), .z_data_out(z_p2), .z_prev_data_out(zp_p2), .y_data_out(y_p2),
        .y_wraddress(y_wraddress), .y_data_in(y_data_in), .y_wren(y_wren),
        .x_rdaddress(x_rdaddress), .v_rdaddress(v_rdaddress), .g_rdaddress(g_rdaddress),
        .x_data_out(x_p2), .v_data_out(v_p2), .g_data_out(g_p2),
        .g_wraddress(g_wraddress), .g_data_in(g_data_in), .g_wren(g_wren),
        .eps_pri(eps_pri), .eps_dual(eps_dual),
        .pri_res_u(pri_res_u), .pri_res_x(pri_res_x), .dual_res(dual_res),
        .converged(converged), .done(done)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int mag(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp_nh(input int unsigned ah);
        if (ah < 2) return 2;
        if (ah > HZ) return HZ;
        return int'(ah);
    endfunction

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return 16'($urandom_range(0, 2047)) - 16'd1024;
            2: return ($urandom_range(0, 1) != 0) ? 16'h7F00 + 16'($urandom_range(0, 255))
                                                  : 16'h8000 + 16'($urandom_range(0, 255));
            default: return 16'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic clear_mems();
        for (int a = 0; a < 512; a++) begin
            u_mem[a] = '0; z_mem[a] = '0; zp_mem[a] = '0; y_mem[a] = '0;
            x_mem[a] = '0; v_mem[a] = '0; g_mem[a] = '0;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 512; a++) begin
            u_mem[a] = rnd_word(); z_mem[a] = rnd_word(); zp_mem[a] = rnd_word();
            y_mem[a] = rnd_word(); x_mem[a] = rnd_word(); v_mem[a] = rnd_word();
            g_mem[a] = rnd_word();
        end
    endtask

    // Expected sweep results straight from the update and residual rules.
    task automatic compute_model(input int nh);
        int d;
        exp_ru = 0; exp_rx = 0; exp_rd = 0;
        for (int a = 0; a < ID * (nh - 1); a++) begin
            d = sat(int'(u_mem[a]) - int'(z_mem[a]));
            exp_y[a] = sat(int'(y_mem[a]) + d);
            if (mag(d) > exp_ru) exp_ru = mag(d);
            d = sat(int'(z_mem[a]) - int'(zp_mem[a]));
            if (mag(d) > exp_rd) exp_rd = mag(d);
        end
        for (int a = 0; a < SD * nh; a++) begin
            d = sat(int'(x_mem[a]) - int'(v_mem[a]));
            exp_g[a] = sat(int'(g_mem[a]) + d);
            if (mag(d) > exp_rx) exp_rx = mag(d);
        end
        exp_conv = (((exp_ru > exp_rx) ? exp_ru : exp_rx) <= int'(eps_pri) &&
                    exp_rd <= int'(eps_dual)) ? 1 : 0;
    endtask

    task automatic run_sweep(input int unsigned ah, input int hold_cycles);
        int nh, nu, e, writes, done_cyc, overlaps, bad, j;
        nh = clamp_nh(ah);
        nu = ID * (nh - 1);
        e  = nu + SD * nh;
        compute_model(nh);
        @(negedge clk);
        active_horizon = ah;
        start = 1'b1;
        @(posedge clk);
        writes = 0; done_cyc = 0; overlaps = 0;
        for (int cyc = 1; cyc <= 4 * e + 40; cyc++) begin
            @(negedge clk);
            if (y_wren && g_wren) overlaps++;
            if (y_wren || g_wren) begin
                j = writes;
                check_val("wr_cycle", cyc, 4 * j + 4);
                if (j >= e) begin
                    check_val("extra_write", j, e - 1);
                end else if (j < nu) begin
                    check_val("y_wren", y_wren, 1);
                    check_val("y_addr", y_wraddress, j);
                    check_val("y_data", y_data_in, exp_y[j]);
                end else begin
                    check_val("g_wren", g_wren, 1);
                    check_val("g_addr", g_wraddress, j - nu);
                    check_val("g_data", g_data_in, exp_g[j - nu]);
                end
                writes++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check_val("done_cycle", done_cyc, 4 * e + 1);
        check_val("write_count", writes, e);
        check_val("wren_overlap", overlaps, 0);
`ifdef DUAL_UPDATE_RESIDUAL_EN
        check_val("pri_res_u", pri_res_u, exp_ru);
        check_val("pri_res_x", pri_res_x, exp_rx);
        check_val("dual_res", dual_res, exp_rd);
        check_val("converged", converged, exp_conv);
`else
        check_val("res_tied_0", {pri_res_u, pri_res_x}, 0);
        check_val("dual_tied_0", {dual_res, converged}, 0);
`endif
        bad = 0;
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            if (!done || y_wren || g_wren) bad++;
        end
        if (hold_cycles > 0) check_val("start_held", bad, 0);
        start = 1'b0;
        @(negedge clk);
        check_val("done_drop", done, 0);
        check_val("conv_drop", converged, 0);
`ifdef DUAL_UPDATE_RESIDUAL_EN
        check_val("res_hold", pri_res_u, exp_ru);
`endif
    endtask

    task automatic mid_sweep_reset();
        int bad;
        fill_random();
        @(negedge clk);
        active_horizon = 30;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 50; c++) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_val("mid_rst_outputs", any_out, 0);
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (y_wren || g_wren || done) bad++;
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (y_wren || g_wren || done) bad++;
        end
        check_val("post_rst_quiet", bad, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_mems();
        rst = 1'b1;
        start = 1'b0;
        active_horizon = '0;
        eps_pri = '0;
        eps_dual = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", any_out, 0);
        rst = 1'b0;

        // Nominal element at index 0, minimal horizon.
        clear_mems();
        u_mem[0] = 16'h0200; z_mem[0] = 16'h0100; y_mem[0] = 16'h0080; zp_mem[0] = 16'h0100;
        run_sweep(0, 0);

        // Saturating y and g updates.
        clear_mems();
        y_mem[1] = 16'h7F00; u_mem[1] = 16'h7000; z_mem[1] = 16'h0000;
        x_mem[0] = 16'h8000; v_mem[0] = 16'h0100; g_mem[0] = 16'h0000;
        run_sweep(5, 0);

        // Zero residuals converge; one z_prev off by one LSB does not.
        for (int a = 0; a < 512; a++) begin
            z_mem[a] = rnd_word(); u_mem[a] = z_mem[a]; zp_mem[a] = z_mem[a];
            x_mem[a] = rnd_word(); v_mem[a] = x_mem[a];
            y_mem[a] = rnd_word(); g_mem[a] = rnd_word();
        end
        eps_pri = '0;
        eps_dual = '0;
        run_sweep(7, 0);
        z_mem[3] = 16'h0010; u_mem[3] = 16'h0010; zp_mem[3] = 16'h0011;
        run_sweep(7, 0);

        // Random data, clamped full horizon with start held long after done.
        fill_random();
        eps_pri = 16'($urandom_range(0, 32767));
        eps_dual = 16'($urandom_range(0, 32767));
        run_sweep(100, 2000);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            eps_pri = 16'($urandom_range(0, 32767));
            eps_dual = 16'($urandom_range(0, 32767));
            run_sweep($urandom_range(0, 40), 3);
        end

        mid_sweep_reset();
        fill_random();
        eps_pri = 16'h7FFF;
        eps_dual = 16'h7FFF;
        run_sweep(30, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
